// File: rtl/cv32e40p_obi_mem_responder.sv
// OBI memory responder: word RAM, outstanding-limited grant, fixed-latency in-order responses.
// Optional random grant stalls are enabled by defining CV32E40P_OBI_RESP_STALL_EN.
module cv32e40p_obi_mem_responder #(
  parameter int unsigned DEPTH           = 1024,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic [3:0]  outstanding_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]        mem_q [DEPTH];
  logic [AW-1:0]      word;
  logic               stall;
  logic               accept;
  logic [LATENCY-1:0] valid_q, valid_d;
  logic [31:0]        data_q [LATENCY];
  logic [31:0]        data_d [LATENCY];
  logic [3:0]         outstanding_q, outstanding_d;

  // Offset from the base, reduced to a word index; out-of-range addresses wrap.
  assign word = AW'((addr_i - BASE_ADDR) >> 2);

`ifdef CV32E40P_OBI_RESP_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // A response retiring this cycle frees its slot only from the next cycle on.
  assign gnt_o  = req_i & ~rst_i & (outstanding_q < 4'(MAX_OUTSTANDING)) & ~stall;
  assign accept = req_i & gnt_o;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    valid_d    = '0;
    data_d     = '{default: '0};
    valid_d[0] = accept;
    data_d[0]  = we_i ? 32'h0 : mem_q[word];
    for (int i = 1; i < LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = data_q[i-1];
    end
    outstanding_d = outstanding_q + 4'(accept) - 4'(rvalid_o);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      valid_q       <= '0;
      outstanding_q <= '0;
    end else begin
      valid_q       <= valid_d;
      outstanding_q <= outstanding_d;
    end
  end

  // NOTE: the RAM and response data carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk_i) begin
    data_q <= data_d;
    if (accept && we_i) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) mem_q[word][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  assign rvalid_o      = valid_q[LATENCY-1];
  assign rdata_o       = rvalid_o ? data_q[LATENCY-1] : 32'h0;
  assign outstanding_o = outstanding_q;

  a_addr_phase_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (req_i && !gnt_o) |=> (req_i && $stable(addr_i) && $stable(we_i) &&
                           $stable(be_i) && $stable(wdata_i)));

  a_rvalid_needs_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
    rvalid_o |-> (outstanding_q != 4'd0));

endmodule
